iter_divider: RTL

Iterative radix-2 restoring divider that forms the responder side of the MDU divide handshake. It accepts a dividend, a divisor and a signedness flag on a valid/ready request channel and computes one quotient bit per cycle. It returns quotient and remainder on a valid/ready result channel. It sits beside the multiplier inside the MDU, is driven from the last MDU stage, and is flushed through its reset.

---
 rtl/iter_divider_if.sv | 25 ++
 rtl/iter_divider.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/iter_divider_if.sv
// Request/result handshake bundle for the MDU divider.
// master: the MDU stage issuing divides; slave: the divider itself.
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             div_valid_i;
  logic             div_ready_o;
  logic             div_signed_i;
  logic [WIDTH-1:0] z_i;
  logic [WIDTH-1:0] d_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] q_o;
  logic [WIDTH-1:0] s_o;

  modport master (
    output div_valid_i, div_signed_i, z_i, d_i, res_ready_i,
    input  div_ready_o, res_valid_o, q_o, s_o
  );

  modport slave (
    input  div_valid_i, div_signed_i, z_i, d_i, res_ready_i,
    output div_ready_o, res_valid_o, q_o, s_o
  );
endinterface

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed and unsigned modes; divide-by-zero yields q=all ones, s=dividend.
// Optional feature macro: ITER_DIVIDER_EARLY_OUT_EN -- when defined, a
// request with |Z| < |D| (D nonzero) bypasses the iterations and completes
// one cycle after accept.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  iter_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH:0]   r_reg, r_next;         // partial remainder, one bit wider
  logic [WIDTH-1:0] a_reg, a_next;         // dividend bits out, quotient bits in
  logic [WIDTH-1:0] d_mag_reg, d_mag_next;
  logic [WIDTH-1:0] z_raw_reg, z_raw_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_s_reg, neg_s_next;
  logic             dz_reg, dz_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] s_reg, s_next;

  // Operand magnitudes at the request port (two's-complement negate; the
  // most negative value maps onto itself, which is correct as unsigned).
  logic [WIDTH-1:0] z_mag, d_mag;
  logic             d_zero;

  // One restoring step on the current state.
  logic [WIDTH:0]   r_shift;
  logic             q_bit;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] a_step;

  // Operand conditioning for the request channel.
  always_comb begin
    z_mag  = (bus.div_signed_i && bus.z_i[WIDTH-1]) ? -bus.z_i : bus.z_i;
    d_mag  = (bus.div_signed_i && bus.d_i[WIDTH-1]) ? -bus.d_i : bus.d_i;
    d_zero = (bus.d_i == '0);
  end

  // Shift {r,a} left by one, then trial-subtract |D|.
  always_comb begin
    r_shift = {r_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    q_bit   = (r_shift >= {1'b0, d_mag_reg});
    r_step  = q_bit ? (r_shift - {1'b0, d_mag_reg}) : r_shift;
    a_step  = {a_reg[WIDTH-2:0], q_bit};
  end

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    a_next     = a_reg;
    d_mag_next = d_mag_reg;
    z_raw_next = z_raw_reg;
    neg_q_next = neg_q_reg;
    neg_s_next = neg_s_reg;
    dz_next    = dz_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    s_next     = s_reg;

    case (state_reg)
      IDLE: begin
        // Ready is high whenever in IDLE outside reset; reset is handled
        // in the register block and overrides any accept.
        if (bus.div_valid_i) begin
          r_next     = '0;
          a_next     = z_mag;
          d_mag_next = d_mag;
          z_raw_next = bus.z_i;
          neg_q_next = bus.div_signed_i & (bus.z_i[WIDTH-1] ^ bus.d_i[WIDTH-1]);
          neg_s_next = bus.div_signed_i & bus.z_i[WIDTH-1];
          dz_next    = d_zero;
          cnt_next   = CW'(WIDTH);
          state_next = CALC;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
          // Quotient is trivially zero and the remainder is the dividend.
          if (!d_zero && (z_mag < d_mag)) begin
            q_next     = '0;
            s_next     = bus.z_i;
            state_next = DONE;
          end
`endif
        end
      end

      CALC: begin
        r_next   = r_step;
        a_next   = a_step;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          if (dz_reg) begin
            // Divide by zero bypasses sign fix-up in both modes.
            q_next = '1;
            s_next = z_raw_reg;
          end else begin
            q_next = neg_q_reg ? -a_step : a_step;
            s_next = neg_s_reg ? -r_step[WIDTH-1:0] : r_step[WIDTH-1:0];
          end
        end
      end

      DONE: begin
        if (bus.res_ready_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset also acts as the MDU flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      a_reg     <= '0;
      d_mag_reg <= '0;
      z_raw_reg <= '0;
      neg_q_reg <= 1'b0;
      neg_s_reg <= 1'b0;
      dz_reg    <= 1'b0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      s_reg     <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      a_reg     <= a_next;
      d_mag_reg <= d_mag_next;
      z_raw_reg <= z_raw_next;
      neg_q_reg <= neg_q_next;
      neg_s_reg <= neg_s_next;
      dz_reg    <= dz_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
      s_reg     <= s_next;
    end
  end

  // Handshake outputs; result valid comes straight from the state register.
  always_comb begin
    bus.div_ready_o = (state_reg == IDLE) & ~rst;
    bus.res_valid_o = (state_reg == DONE);
    bus.q_o         = q_reg;
    bus.s_o         = s_reg;
  end

endmodule
